// File: rtl/mul_seq.sv
// Sequential shift-free multiplier: repeated ALU adds of op_a, op_b times.
// Optional saturation of the result on carry-out: define MUL_SEQ_SAT_EN.
module mul_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_o,
  input  logic         alu_of,
  input  logic         alu_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [N-1:0] C_ONE = N'(1);

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_a;
  logic [N-1:0] r_cnt;
  logic         r_busy;
  logic         r_ovf;
  logic         r_err;
  logic         w_zero;

  assign w_zero = (op_a == '0) || (op_b == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: zero operand skips the add loop; ALU error aborts it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_zero ? S_DONE : S_ADD;
      end
      S_ADD: begin
        if (alu_err || (r_cnt == C_ONE)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on start, accumulate one add per ADD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= op_a;
            r_cnt  <= op_b;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S_ADD: begin
          if (alu_err) begin
            r_err <= 1'b1;
          end else begin
            r_acc <= alu_o;
            r_ovf <= r_ovf | alu_of;
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_DONE:  r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = (r_state == S_DONE);
  assign ovf    = r_ovf;
  assign err    = r_err;
  assign alu_a  = r_acc;
  assign alu_b  = r_a;
  assign alu_op = 4'b0000;

`ifdef MUL_SEQ_SAT_EN
  assign result = r_ovf ? {N{1'b1}} : r_acc;
`else
  assign result = r_acc;
`endif

endmodule
